// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master controller and the matching SPI slave:
//   - command encodings carried in the two top frame bits
//   - master FSM state enumeration
//   - frame / data widths and the bit-counter width
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int FRAME_W = 10;  // MOSI frame width {cmd, payload}, no select bit
  localparam int DATA_W  = 8;   // payload and read-reply width
  // Counts FRAME_W-1, DATA_W-1 and RD_LAT-1 (RD_LAT <= 7); 9 is the maximum.
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    SHIFT,
    WAIT,
    RECV,
    END
  } state_e;

endpackage

// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
// Single-clock SPI master. One command per start/busy handshake: sends the
// select bit (cmd[1]) then the 10-bit frame {cmd, wdata} MSB first under SS_n.
// For read-data commands it waits RD_LAT cycles and captures an 8-bit reply
// from MISO, MSB first.
//
// Ports:
//   clk          in   system clock, also the SPI bit clock
//   rst          in   asynchronous active-high reset
//   start        in   host request, sampled only in IDLE
//   cmd[1:0]     in   command (see spi_pkg::cmd_e)
//   wdata[7:0]   in   payload (address or data byte)
//   busy         out  transaction in progress
//   done         out  one-cycle pulse at the end of every transaction
//   rdata[7:0]   out  last captured read reply
//   rdata_valid  out  one-cycle pulse with done, read-data commands only
//   SS_n         out  slave select, active low
//   MOSI         out  serial data to slave
//   MISO         in   serial data from slave
//
// Timing (edge T = accept): state_q leads the registered outputs by one edge,
// so SS_n falls at T+1 (select bit), frame bits appear at T+2..T+11, and done
// rises at T+12 (writes / read-address) or T+20+RD_LAT (read-data).
// -----------------------------------------------------------------------------
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int RD_LAT = 2  // idle cycles between last MOSI bit and first MISO bit, 1..7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  cmd_e                cmd_q, cmd_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ss_n_q, ss_n_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rv_q, rv_d;

  // Next-state and next-output logic. Outputs are decoded from the current
  // state and registered, which gives the one-edge offset between state and pins.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    cmd_d   = cmd_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    ss_n_d  = 1'b1;
    mosi_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rv_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          frame_d = {cmd, wdata};
          cmd_d   = cmd_e'(cmd);
          cnt_d   = CNT_W'(FRAME_W - 1);
          state_d = SEL;
        end
      end

      SEL: begin
        ss_n_d  = 1'b0;
        busy_d  = 1'b1;
        mosi_d  = frame_q[FRAME_W-1];  // cmd[1] doubles as the read/write select bit
        cnt_d   = CNT_W'(FRAME_W - 1);
        state_d = SHIFT;
      end

      SHIFT: begin
        ss_n_d  = 1'b0;
        busy_d  = 1'b1;
        mosi_d  = frame_q[FRAME_W-1];
        frame_d = frame_q << 1;
        if (cnt_q == '0) begin
          if (cmd_q == CMD_RD_DATA) begin
            cnt_d   = CNT_W'(RD_LAT - 1);
            state_d = WAIT;
          end else begin
            state_d = END;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      WAIT: begin
        ss_n_d = 1'b0;
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(DATA_W - 1);
          state_d = RECV;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RECV: begin
        ss_n_d = 1'b0;
        busy_d = 1'b1;
        rx_d   = {rx_q[DATA_W-2:0], MISO};
        if (cnt_q == '0) begin
          state_d = END;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      END: begin
        busy_d = 1'b1;
        done_d = 1'b1;
        if (cmd_q == CMD_RD_DATA) begin
          rv_d    = 1'b1;
          rdata_d = rx_q;  // rdata holds across every other command
        end
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  // NOTE: the datapath registers are reset too, so a frame abandoned by reset
  // leaves nothing stale behind for the next transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      cmd_q   <= CMD_WR_ADDR;
      rx_q    <= '0;
      rdata_q <= '0;
      ss_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      cmd_q   <= cmd_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      ss_n_q  <= ss_n_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
    end
  end

  assign SS_n        = ss_n_q;
  assign MOSI        = mosi_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata_valid = rv_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
// Runs three masters (RD_LAT = 2, 1, 7) from shared host inputs. A per-DUT
// transaction model (accept edge, command, payload, reply) derives the expected
// pin values for every cycle from the offset to the accept edge, and a MISO
// stub per DUT supplies the reply only inside its receive window.
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int N = 3;
  localparam int LATS [N] = '{2, 1, 7};

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       cmd;
  logic [7:0]       wdata;
  logic [N-1:0]     busy, done, rdata_valid, ss_n, mosi, miso;
  logic [7:0]       rdata [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_master_ctrl #(.RD_LAT(LATS[g])) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .cmd         (cmd),
      .wdata       (wdata),
      .busy        (busy[g]),
      .done        (done[g]),
      .rdata       (rdata[g]),
      .rdata_valid (rdata_valid[g]),
      .SS_n        (ss_n[g]),
      .MOSI        (mosi[g]),
      .MISO        (miso[g])
    );
  end

  // Reference model state
  int         cyc;
  bit         active  [N];
  int         t_acc   [N];
  logic [1:0] m_cmd   [N];
  logic [7:0] m_wdata [N];
  logic [7:0] m_reply [N];
  logic [7:0] m_rdata [N];
  logic [7:0] next_reply;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h  {SS_n,MOSI,busy,done,rv,rdata}", tag, got, exp);
    end
  endtask

  function automatic int txn_len(int g);
    return (m_cmd[g] == 2'b11) ? 20 + LATS[g] : 12;
  endfunction

  // Expected {SS_n, MOSI, busy, done, rdata_valid, rdata} after edge cyc.
  function automatic logic [12:0] exp_out(int g);
    logic       s, m, b, d, v;
    logic [9:0] frame;
    int         k, len;
    s = 1'b1; m = 1'b0; b = 1'b0; d = 1'b0; v = 1'b0;
    if (active[g]) begin
      k     = cyc - t_acc[g];
      len   = txn_len(g);
      frame = {m_cmd[g], m_wdata[g]};
      if (k >= 1 && k < len) begin
        s = 1'b0;
        b = 1'b1;
        if (k == 1)       m = m_cmd[g][1];
        else if (k <= 11) m = frame[11-k];
      end else if (k == len) begin
        b = 1'b1;
        d = 1'b1;
        v = (m_cmd[g] == 2'b11);
      end
    end
    return {s, m, b, d, v, m_rdata[g]};
  endfunction

  function automatic logic [12:0] obs_out(int g);
    return {ss_n[g], mosi[g], busy[g], done[g], rdata_valid[g], rdata[g]};
  endfunction

  // MISO for the next edge: reply bit inside the receive window, noise elsewhere.
  task automatic drive_miso();
    int k2, lo;
    for (int g = 0; g < N; g++) begin
      k2 = cyc + 1 - t_acc[g];
      lo = 12 + LATS[g];
      if (active[g] && m_cmd[g] == 2'b11 && k2 >= lo && k2 < lo + 8)
        miso[g] = m_reply[g][7-(k2-lo)];
      else
        miso[g] = 1'($urandom_range(0, 1));
    end
  endtask

  // One clock: update the model at the edge, compare all DUTs at the negedge.
  task automatic step();
    @(posedge clk);
    cyc++;
    for (int g = 0; g < N; g++) begin
      if (rst) begin
        active[g]  = 1'b0;
        m_rdata[g] = 8'h00;
      end else begin
        if (active[g] && m_cmd[g] == 2'b11 && cyc == t_acc[g] + txn_len(g))
          m_rdata[g] = m_reply[g];
        if (start && (!active[g] || cyc > t_acc[g] + txn_len(g))) begin
          active[g]  = 1'b1;
          t_acc[g]   = cyc;
          m_cmd[g]   = cmd;
          m_wdata[g] = wdata;
          m_reply[g] = next_reply;
        end
      end
    end
    @(negedge clk);
    for (int g = 0; g < N; g++)
      check($sformatf("lat%0d_cyc%0d", LATS[g], cyc), {3'b0, obs_out(g)}, {3'b0, exp_out(g)});
    drive_miso();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // One-cycle start pulse; inputs are scrambled afterwards so only the
  // values present at the accept edge can matter.
  task automatic send(input logic [1:0] c, input logic [7:0] d, input logic [7:0] reply);
    start      = 1'b1;
    cmd        = c;
    wdata      = d;
    next_reply = reply;
    step();
    start = 1'b0;
    cmd   = 2'($urandom);
    wdata = 8'($urandom);
  endtask

  // Reset asserted between edges: outputs must return to idle with no edge.
  task automatic async_reset_mid();
    #2;
    rst = 1'b1;
    #1;
    for (int g = 0; g < N; g++) begin
      active[g]  = 1'b0;
      m_rdata[g] = 8'h00;
      check($sformatf("async_rst_lat%0d", LATS[g]), {3'b0, obs_out(g)}, {3'b0, 13'b1_0000_0000_0000});
    end
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    cmd        = 2'b00;
    wdata      = 8'h00;
    miso       = '0;
    next_reply = 8'h00;
    cyc        = 0;
    for (int g = 0; g < N; g++) begin
      active[g]  = 1'b0;
      t_acc[g]   = 0;
      m_cmd[g]   = 2'b00;
      m_wdata[g] = 8'h00;
      m_reply[g] = 8'h00;
      m_rdata[g] = 8'h00;
    end
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    idle(2);

    // Write address A5: MOSI 0 then 0,0,1,0,1,0,0,1,0,1; done at T+12.
    send(2'b00, 8'hA5, 8'h00);
    idle(14);

    // Read data with stub reply C3, then a write that must leave rdata alone.
    send(2'b11, 8'h00, 8'hC3);
    idle(30);
    send(2'b01, 8'h96, 8'h00);
    idle(14);

    // Reset in the middle of SHIFT, then a clean frame.
    send(2'b00, 8'h3C, 8'h00);
    idle(4);
    async_reset_mid();
    send(2'b10, 8'h3C, 8'h00);
    idle(14);
    send(2'b11, 8'h00, 8'h5A);
    idle(30);

    // Start held high with inputs changing every cycle: back-to-back frames,
    // changes during busy ignored.
    start = 1'b1;
    repeat (60) begin
      cmd        = 2'($urandom);
      wdata      = 8'($urandom);
      next_reply = 8'($urandom);
      step();
    end
    start = 1'b0;
    idle(30);

    // Random start pulses, commands, payloads and replies.
    repeat (500) begin
      start      = ($urandom_range(0, 3) == 0);
      cmd        = 2'($urandom);
      wdata      = 8'($urandom);
      next_reply = 8'($urandom);
      step();
    end
    start = 1'b0;
    idle(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
